// File: rtl/pattern_frame_tx_pkg.sv
// pattern_frame_tx_pkg
//   Definitions shared by the sync-pattern link transmitter and detector:
//   one-hot frame state encoding, default sync pattern and its width, and a
//   small helper used to size the per-phase bit counter.
package pattern_frame_tx_pkg;

    localparam int unsigned SYNC_W = 4;
    localparam logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1011;

    // One-hot frame phases.
    typedef enum logic [3:0] {
        StIdle    = 4'b0001,
        StSync    = 4'b0010,
        StPayload = 4'b0100,
        StGap     = 4'b1000
    } tx_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/piso_shift.sv
// piso_shift
//   Parallel-in / serial-out shift register, MSB first. A load takes priority
//   over a shift; zeros fill from the LSB end.
//   Ports:
//     clk_i   in  1      clock, rising edge
//     rst_i   in  1      asynchronous active-high reset (clears the register)
//     load_i  in  1      load data_i
//     data_i  in  WIDTH  parallel word
//     shift_i in  1      shift one position towards the MSB
//     msb_o   out 1      current MSB (next bit to leave)
module piso_shift #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             shift_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] r_sr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sr <= '0;
        end else if (load_i) begin
            r_sr <= data_i;
        end else if (shift_i) begin
            r_sr <= r_sr << 1;
        end
    end

    assign msb_o = r_sr[WIDTH-1];

endmodule

// File: rtl/pattern_frame_tx.sv
// pattern_frame_tx
//   Transmit end of the serial sync-pattern link. A payload word accepted over
//   valid/ready is sent as one frame: sync pattern (MSB first), payload (MSB
//   first), then GAP_BITS zeros. One bit leaves per edge with bit_en_i high.
//   Ports:
//     clk_i        in  1       clock, rising edge
//     rst_i        in  1       asynchronous active-high reset
//     data_i       in  DATA_W  payload word, sampled on accept
//     data_valid_i in  1       payload offered
//     data_ready_o out 1       can accept a payload (idle only)
//     bit_en_i     in  1       bit-slot strobe
//     bit_o        out 1       serial bit
//     bit_valid_o  out 1       bit_o valid this cycle
//     sync_o       out 1       high with the last sync-pattern bit
//     busy_o       out 1       frame in progress
module pattern_frame_tx
    import pattern_frame_tx_pkg::*;
#(
    parameter int unsigned         DATA_W   = 8,
    parameter int unsigned         PAT_W    = SYNC_W,
    parameter logic [PAT_W-1:0]    PATTERN  = SYNC_PATTERN,
    parameter int unsigned         GAP_BITS = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    input  logic              bit_en_i,
    output logic              bit_o,
    output logic              bit_valid_o,
    output logic              sync_o,
    output logic              busy_o
);

    localparam int unsigned CNT_W = $clog2(max3(PAT_W, DATA_W, GAP_BITS) + 1);
    localparam logic [CNT_W-1:0] PAT_LAST  = CNT_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    tx_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bit;
    logic             r_valid;
    logic             r_sync;
    // Holds data_ready_o low until the first edge after reset release.
    logic             r_live;

    logic w_accept;
    logic w_pat_shift;
    logic w_pay_shift;
    logic w_pat_msb;
    logic w_pay_msb;

    assign data_ready_o = (r_state == StIdle) && r_live;
    assign busy_o       = (r_state != StIdle);
    assign w_accept     = data_valid_i && data_ready_o;
    assign w_pat_shift  = (r_state == StSync) && bit_en_i;
    assign w_pay_shift  = (r_state == StPayload) && bit_en_i;

    // The pattern is streamed through its own shifter so no variable bit index is needed.
    piso_shift #(
        .WIDTH (PAT_W)
    ) u_pat_shift (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (w_accept),
        .data_i  (PATTERN),
        .shift_i (w_pat_shift),
        .msb_o   (w_pat_msb)
    );

    piso_shift #(
        .WIDTH (DATA_W)
    ) u_pay_shift (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (w_accept),
        .data_i  (data_i),
        .shift_i (w_pay_shift),
        .msb_o   (w_pay_msb)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_bit   <= 1'b0;
            r_valid <= 1'b0;
            r_sync  <= 1'b0;
            r_live  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            unique case (r_state)
                StIdle: begin
                    r_bit   <= 1'b0;
                    r_valid <= 1'b0;
                    r_sync  <= 1'b0;
                    if (w_accept) begin
                        r_state <= StSync;
                        r_cnt   <= '0;
                    end
                end
                StSync: begin
                    r_valid <= bit_en_i;
                    r_sync  <= bit_en_i && (r_cnt == PAT_LAST);
                    if (bit_en_i) begin
                        r_bit <= w_pat_msb;
                        if (r_cnt == PAT_LAST) begin
                            r_cnt   <= '0;
                            r_state <= StPayload;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                StPayload: begin
                    r_valid <= bit_en_i;
                    r_sync  <= 1'b0;
                    if (bit_en_i) begin
                        r_bit <= w_pay_msb;
                        if (r_cnt == DATA_LAST) begin
                            r_cnt   <= '0;
                            r_state <= (GAP_BITS > 0) ? StGap : StIdle;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                StGap: begin
                    r_valid <= bit_en_i;
                    r_sync  <= 1'b0;
                    if (bit_en_i) begin
                        r_bit <= 1'b0;
                        if (r_cnt == GAP_LAST) begin
                            r_cnt   <= '0;
                            r_state <= StIdle;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_valid <= 1'b0;
                    r_sync  <= 1'b0;
                end
            endcase
        end
    end

    assign bit_o       = r_bit;
    assign bit_valid_o = r_valid;
    assign sync_o      = r_sync;

endmodule

// File: tb/tb_pattern_frame_tx.sv
module tb_pattern_frame_tx;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] data_i;
    logic       data_valid_i;
    logic       data_ready_o;
    logic       bit_en_i;
    logic       bit_o;
    logic       bit_valid_o;
    logic       sync_o;
    logic       busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference Moore detector for 1011, non-overlapping, fed from the serial stream.
    int det_s    = 0;
    int det_hits = 0;

    always #5 clk_i = ~clk_i;

    pattern_frame_tx dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .data_ready_o (data_ready_o),
        .bit_en_i     (bit_en_i),
        .bit_o        (bit_o),
        .bit_valid_o  (bit_valid_o),
        .sync_o       (sync_o),
        .busy_o       (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic det_step(input logic b);
        case (det_s)
            0: det_s = b ? 1 : 0;
            1: det_s = b ? 1 : 2;
            2: det_s = b ? 3 : 0;
            3: begin
                if (b) begin
                    det_hits++;
                    det_s = 0;
                end else begin
                    det_s = 2;
                end
            end
            default: det_s = 0;
        endcase
    endtask

    // Accept word d, then strobe bit_en_i every 'period' cycles and check the whole frame.
    // With hold=1, data_valid_i stays high offering nxt while the frame runs.
    task automatic send_frame(input logic [7:0] d, input int period, input logic hold,
                              input logic [7:0] nxt);
        logic [12:0] exp_s;
        int          k;
        exp_s = {4'b1011, d, 1'b0};
        chk("ready_pre", {31'd0, data_ready_o}, 32'd1);
        data_i       = d;
        data_valid_i = 1'b1;
        bit_en_i     = (period == 1);
        step();
        chk("accept_no_bit", {31'd0, bit_valid_o}, 32'd0);
        chk("busy_on", {31'd0, busy_o}, 32'd1);
        chk("ready_on_accept", {31'd0, data_ready_o}, 32'd0);
        data_valid_i = hold;
        data_i       = nxt;
        k = 0;
        for (int c = 0; c < 200 && k < 13; c++) begin
            bit_en_i = ((c % period) == period - 1);
            step();
            if (bit_en_i) begin
                chk("valid", {31'd0, bit_valid_o}, 32'd1);
                chk("bit", {31'd0, bit_o}, {31'd0, exp_s[12-k]});
                chk("sync", {31'd0, sync_o}, {31'd0, k == 3});
                if (bit_valid_o) det_step(bit_o);
                k++;
                chk("busy", {31'd0, busy_o}, {31'd0, k < 13});
                chk("ready", {31'd0, data_ready_o}, {31'd0, k == 13});
            end else begin
                chk("valid_off", {31'd0, bit_valid_o}, 32'd0);
                chk("bit_hold", {31'd0, bit_o}, (k == 0) ? 32'd0 : {31'd0, exp_s[13-k]});
                chk("sync_off", {31'd0, sync_o}, 32'd0);
                chk("ready_off", {31'd0, data_ready_o}, 32'd0);
            end
        end
        bit_en_i = 1'b0;
        chk("frame_len", k, 32'd13);
    endtask

    // Start a frame, let 4 sync + 5 payload bits out, then reset asynchronously mid-cycle.
    task automatic reset_mid_frame(input logic [7:0] d);
        logic [12:0] exp_s;
        exp_s = {4'b1011, d, 1'b0};
        data_i       = d;
        data_valid_i = 1'b1;
        bit_en_i     = 1'b0;
        step();
        data_valid_i = 1'b0;
        bit_en_i     = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            chk("pre_rst_bit", {31'd0, bit_o}, {31'd0, exp_s[12-k]});
        end
        chk("pre_rst_valid", {31'd0, bit_valid_o}, 32'd1);
        #3;
        rst_i = 1'b1;
        #1;
        chk("rst_valid", {31'd0, bit_valid_o}, 32'd0);
        chk("rst_bit", {31'd0, bit_o}, 32'd0);
        chk("rst_sync", {31'd0, sync_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_ready", {31'd0, data_ready_o}, 32'd0);
        #1;
        rst_i    = 1'b0;
        bit_en_i = 1'b0;
        chk("rel_ready_low", {31'd0, data_ready_o}, 32'd0);
        step();
        chk("rel_ready", {31'd0, data_ready_o}, 32'd1);
        chk("rel_busy", {31'd0, busy_o}, 32'd0);
        chk("rel_valid", {31'd0, bit_valid_o}, 32'd0);
    endtask

    initial begin
        rst_i        = 1'b1;
        data_i       = 8'h00;
        data_valid_i = 1'b0;
        bit_en_i     = 1'b0;
        #12;
        chk("init_ready", {31'd0, data_ready_o}, 32'd0);
        chk("init_busy", {31'd0, busy_o}, 32'd0);
        chk("init_valid", {31'd0, bit_valid_o}, 32'd0);
        chk("init_bit", {31'd0, bit_o}, 32'd0);
        chk("init_sync", {31'd0, sync_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("rel0_ready_low", {31'd0, data_ready_o}, 32'd0);
        step();
        chk("rel0_ready", {31'd0, data_ready_o}, 32'd1);

        // Constant strobe, A5.
        send_frame(8'hA5, 1, 1'b0, 8'h00);
        // Strobe every third cycle, 3C.
        send_frame(8'h3C, 3, 1'b0, 8'h00);
        // FF then 00 with valid held high throughout.
        send_frame(8'hFF, 1, 1'b1, 8'h00);
        send_frame(8'h00, 1, 1'b0, 8'h00);

        // Reset mid-payload, then a fresh frame restarts with the sync pattern.
        reset_mid_frame(8'hC3);
        send_frame(8'h81, 1, 1'b0, 8'h00);

        // Strobes while idle do nothing.
        bit_en_i = 1'b1;
        step();
        step();
        chk("idle_en_valid", {31'd0, bit_valid_o}, 32'd0);
        chk("idle_en_busy", {31'd0, busy_o}, 32'd0);
        bit_en_i = 1'b0;

        // Loopback into the reference detector: three all-zero payload frames.
        det_s    = 0;
        det_hits = 0;
        for (int f = 0; f < 3; f++) send_frame(8'h00, 2, 1'b0, 8'h00);
        chk("det_hits", det_hits, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
